btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Per-button input conditioner that sits directly upstream of the simple I/O peripheral's `btn_in` port. It synchronises the raw board pushbutton pins, debounces them, and outputs clean levels to the peripheral's button register. It also emits one-cycle press, release and auto-repeat pulses for game logic that must not poll the bus. Each button channel is independent; a channel is a 2-flop synchroniser, a debounce counter and a 3-state auto-repeat FSM.

## Interface
- `NUM_BTN`, 3: number of button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive clk cycles the synchronised input must differ from the debounced level before that level flips. Must be >= 1.
- `REPEAT_DELAY_CYCLES`, 50000000: cycles from the press pulse to the first repeat pulse. Must be >= 2.
- `REPEAT_RATE_CYCLES`, 10000000: cycles between successive repeat pulses. Must be >= 1.
- `REPEAT_MASK`, {NUM_BTN{1'b1}}: bit i = 1 enables auto-repeat on channel i.

Ports:
- `clk`  in  1  system clock (Bus2IP_Clk domain).
- `rstn`  in  1  reset, synchronous, active-low.
- `btn_raw`  in  NUM_BTN  asynchronous pushbutton pins, active-high.
- `btn_level`  out  NUM_BTN  debounced level; connects to `btn_in`.
- `btn_press`  out  NUM_BTN  1-cycle pulse on a debounced 0->1 transition.
- `btn_release`  out  NUM_BTN  1-cycle pulse on a debounced 1->0 transition.
- `btn_repeat`  out  NUM_BTN  1-cycle auto-repeat pulse while held.

## Operation
- Reset (rstn=0 at a clk edge) clears all state in every channel:
  - synchroniser flops, debounce counter and repeat counter = 0;
  - FSM state = IDLE;
  - all outputs = 0.
- Synchroniser: `s1 <= btn_raw`, `s2 <= s1`. Only `s2` feeds the logic.
- Debounce:
  - If `s2 == btn_level`: counter <= 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: `btn_level` <= `s2`, counter <= 0, and the matching press or release pulse is asserted at this same edge.
  - Else: counter <= counter+1.
  - Any bounce back to the current level restarts the count. Glitches shorter than DEBOUNCE_CYCLES are never propagated.
- Counter widths are $clog2 of the respective cycle parameter, minimum 1 bit. Counters never wrap, because they are reset at their terminal count.
- Auto-repeat FSM, one per channel; runs only if the channel's REPEAT_MASK bit is 1, otherwise it stays in IDLE.
  - IDLE: on the press event -> DELAY, with rcnt <= 0.
  - DELAY:
    - Release event -> IDLE (takes priority).
    - Else, if rcnt == REPEAT_DELAY_CYCLES-1: pulse `btn_repeat`, rcnt <= 0, -> REPEAT.
    - Else: rcnt <= rcnt+1.
  - REPEAT:
    - Release event -> IDLE (takes priority).
    - Else, if rcnt == REPEAT_RATE_CYCLES-1: pulse `btn_repeat`, rcnt <= 0.
    - Else: rcnt <= rcnt+1.
- No repeat pulse is ever issued in the same cycle as a press or release pulse.
- Channels never interact. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- A raw transition sampled at edge k, and stable thereafter, reaches `s2` at edge k+1.
- `btn_level` and the press/release pulse update at edge k+1+DEBOUNCE_CYCLES.
- Pulse outputs are registered and high for exactly one cycle.
- The first `btn_repeat` occurs REPEAT_DELAY_CYCLES cycles after the `btn_press` cycle. Later repeats occur every REPEAT_RATE_CYCLES cycles.
- Reset mid-operation: at the next edge with rstn=0, all outputs go to 0 and the FSM goes to IDLE.
  - No release pulse is generated by reset.
  - After reset, a still-held button is reported as a fresh press after the full synchroniser + debounce latency.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5, NUM_BTN=3, REPEAT_MASK=3'b011.

1. Reset: hold rstn=0 for 3 cycles with btn_raw=3'b111 -> all outputs 0 during reset. After release, btn_level=3'b111 and btn_press=3'b111 exactly 5 cycles later (k+1+4).
2. Glitch rejection: pulse btn_raw[0] high for 3 cycles, then low -> btn_level stays 0 and no pulses. A 4-cycle-stable high -> press pulse 5 cycles after the first sample.
3. Bounce restart: pattern high 2, low 1, high stable -> level rises 5 cycles after the final rising sample; exactly one press pulse.
4. Auto-repeat: hold btn[1] for 40 cycles after press -> repeat pulses at press+10, +15, +20, +25, +30, +35. On release: one release pulse, no further repeats.
5. Mask: hold btn[2] for 40 cycles -> press pulse and later release pulse only; btn_repeat[2] never asserts.
6. Mid-repeat reset: assert rstn=0 one cycle at press+12 -> all outputs 0 next edge and FSM in IDLE. With the button still held, a new press appears 5 cycles after reset deasserts, and the first repeat follows 10 cycles after that press.

Source files
------------

// File: rtl/btn_conditioner.sv
// Pushbutton input conditioner: 2-flop synchroniser, debounce counter and
// auto-repeat FSM per channel, producing clean levels plus 1-cycle event pulses.
module btn_conditioner #(
  parameter int                 NUM_BTN             = 3,
  parameter int                 DEBOUNCE_CYCLES     = 1000000,
  parameter int                 REPEAT_DELAY_CYCLES = 50000000,
  parameter int                 REPEAT_RATE_CYCLES  = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK         = {NUM_BTN{1'b1}}
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DL_W = (REPEAT_DELAY_CYCLES > 1) ? $clog2(REPEAT_DELAY_CYCLES) : 1;
  localparam int RT_W = (REPEAT_RATE_CYCLES > 1) ? $clog2(REPEAT_RATE_CYCLES) : 1;
  localparam int RC_W = (DL_W > RT_W) ? DL_W : RT_W;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DLY_LAST  = RC_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RC_W-1:0] RATE_LAST = RC_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_t;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic            sync_p0;
    logic            sync_p1;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            repeat_q;
    logic [DB_W-1:0] dcnt;
    logic            db_done;
    logic            press_evt;
    logic            release_evt;
    logic            rpt_en;
    rpt_state_t      state;
    rpt_state_t      state_nxt;
    logic [RC_W-1:0] rcnt;
    logic [RC_W-1:0] rcnt_nxt;
    logic            repeat_nxt;

    // Events are taken combinationally so the FSM moves on the same edge
    // that registers the press/release pulse.
    assign db_done     = (sync_p1 != level_q) && (dcnt == DB_LAST);
    assign press_evt   = db_done & sync_p1;
    assign release_evt = db_done & ~sync_p1;
    assign rpt_en      = REPEAT_MASK[i];

    // Synchroniser and debounce stage
    always_ff @(posedge clk) begin
      if (!rstn) begin
        sync_p0   <= 1'b0;
        sync_p1   <= 1'b0;
        level_q   <= 1'b0;
        dcnt      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_p0   <= btn_raw[i];
        sync_p1   <= sync_p0;
        press_q   <= press_evt;
        release_q <= release_evt;
        if (sync_p1 == level_q) begin
          dcnt <= '0;
        end else if (dcnt == DB_LAST) begin
          level_q <= sync_p1;
          dcnt    <= '0;
        end else begin
          dcnt <= dcnt + DB_W'(1);
        end
      end
    end

    // Auto-repeat stage
    always_ff @(posedge clk) begin
      if (!rstn) begin
        state    <= ST_IDLE;
        rcnt     <= '0;
        repeat_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        rcnt     <= rcnt_nxt;
        repeat_q <= repeat_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      rcnt_nxt   = rcnt;
      repeat_nxt = 1'b0;
      if (!rpt_en) begin
        state_nxt = ST_IDLE;
        rcnt_nxt  = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (press_evt) begin
              state_nxt = ST_DELAY;
              rcnt_nxt  = '0;
            end
          end
          ST_DELAY: begin
            if (release_evt) begin
              state_nxt = ST_IDLE;
            end else if (rcnt == DLY_LAST) begin
              repeat_nxt = 1'b1;
              rcnt_nxt   = '0;
              state_nxt  = ST_REPEAT;
            end else begin
              rcnt_nxt = rcnt + RC_W'(1);
            end
          end
          ST_REPEAT: begin
            if (release_evt) begin
              state_nxt = ST_IDLE;
            end else if (rcnt == RATE_LAST) begin
              repeat_nxt = 1'b1;
              rcnt_nxt   = '0;
            end else begin
              rcnt_nxt = rcnt + RC_W'(1);
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: reset, glitch rejection, bounce restart,
// auto-repeat timing, repeat mask and reset in the middle of a repeat run.
module tb_btn_conditioner;

  localparam int NUM_BTN = 3;

  logic               clk;
  logic               rstn;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(
    .NUM_BTN            (NUM_BTN),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (5),
    .REPEAT_MASK        (3'b011)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs as {level, press, release, repeat}, 3 bits each.
  function automatic logic [11:0] outs();
    return {btn_level, btn_press, btn_release, btn_repeat};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n, input logic [2:0] lvl);
    for (int c = 1; c <= n; c++) begin
      tick();
      chk($sformatf("%s quiet c=%0d", tag, c), outs(), {lvl, 9'b0});
    end
  endtask

  // Drive a new raw value and expect the debounced edge on the 6th cycle.
  task automatic transition(input string tag, input logic [2:0] new_raw,
                            input logic [2:0] old_lvl, input logic [2:0] prs,
                            input logic [2:0] rel);
    btn_raw = new_raw;
    quiet(tag, 5, old_lvl);
    tick();
    chk($sformatf("%s edge", tag), outs(), {new_raw, prs, rel, 3'b000});
  endtask

  // Cycle c counts from the press pulse; raw drops after the check at set_c.
  task automatic run_hold(input string tag, input logic [2:0] ch, input bit rep_en,
                          input int set_c, input int n);
    int rel_c;
    logic [2:0] lvl, rel, rep;
    rel_c = set_c + 6;
    for (int c = 1; c <= n; c++) begin
      tick();
      lvl = (c < rel_c) ? ch : 3'b000;
      rel = (c == rel_c) ? ch : 3'b000;
      rep = (rep_en && c >= 10 && c < rel_c && ((c - 10) % 5) == 0) ? ch : 3'b000;
      chk($sformatf("%s c=%0d", tag, c), outs(), {lvl, 3'b000, rel, rep});
      if (c == set_c) btn_raw = 3'b000;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    btn_raw = 3'b111;

    // 1: reset with all buttons held, then fresh press on all channels
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("reset c=%0d", c), outs(), 12'b0);
    end
    rstn = 1'b1;
    transition("rst_press", 3'b111, 3'b000, 3'b111, 3'b000);
    transition("rst_release", 3'b000, 3'b111, 3'b000, 3'b111);
    quiet("after_release", 12, 3'b000);

    // 2: 3-cycle glitch rejected, then a stable press/release
    btn_raw = 3'b001;
    quiet("glitch_hi", 3, 3'b000);
    btn_raw = 3'b000;
    quiet("glitch_lo", 8, 3'b000);
    transition("stable_press", 3'b001, 3'b000, 3'b001, 3'b000);
    transition("stable_release", 3'b000, 3'b001, 3'b000, 3'b001);
    quiet("t2_end", 3, 3'b000);

    // 3: bounce high 2, low 1, then high stable
    btn_raw = 3'b001;
    quiet("bounce_hi", 2, 3'b000);
    btn_raw = 3'b000;
    quiet("bounce_lo", 1, 3'b000);
    transition("bounce_press", 3'b001, 3'b000, 3'b001, 3'b000);
    quiet("bounce_single", 1, 3'b001);
    transition("bounce_release", 3'b000, 3'b001, 3'b000, 3'b001);
    quiet("t3_end", 3, 3'b000);

    // 4: auto-repeat on btn[1]; release lands on a repeat slot and wins
    transition("rep_press", 3'b010, 3'b000, 3'b010, 3'b000);
    run_hold("rep_hold", 3'b010, 1'b1, 34, 55);

    // 5: btn[2] is masked, no repeats
    transition("mask_press", 3'b100, 3'b000, 3'b100, 3'b000);
    run_hold("mask_hold", 3'b100, 1'b0, 34, 55);

    // 6: one-cycle reset at press+12 while held
    transition("mid_press", 3'b010, 3'b000, 3'b010, 3'b000);
    run_hold("mid_pre", 3'b010, 1'b1, 1000, 11);
    rstn = 1'b0;
    tick();
    chk("mid_reset", outs(), 12'b0);
    rstn = 1'b1;
    transition("mid_repress", 3'b010, 3'b000, 3'b010, 3'b000);
    run_hold("mid_post", 3'b010, 1'b1, 10, 25);
    quiet("t6_end", 5, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
